// File: rtl/pipe_dexe.sv
// ID/EX pipeline register and execute stage: latches decoded controls/operands,
// then computes the ALU/shift result or the jal link address from the latched values.
module pipe_dexe #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             dwreg,
  input  logic             dm2reg,
  input  logic             dwmem,
  input  logic             djal,
  input  logic [3:0]       daluc,
  input  logic             daluimm,
  input  logic             dshift,
  input  logic [WIDTH-1:0] da,
  input  logic [WIDTH-1:0] db,
  input  logic [WIDTH-1:0] dimm,
  input  logic [4:0]       drn,
  input  logic [WIDTH-1:0] dpc4,
  output logic             ewreg,
  output logic             em2reg,
  output logic             ewmem,
  output logic [4:0]       ern,
  output logic [WIDTH-1:0] ealu,
  output logic [WIDTH-1:0] eb
);

  typedef struct packed {
    logic             wreg;
    logic             m2reg;
    logic             wmem;
    logic             jal;
    logic [3:0]       aluc;
    logic             aluimm;
    logic             shift;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] imm;
    logic [4:0]       rn0;
    logic [WIDTH-1:0] pc4;
  } ex_regs_t;

  ex_regs_t ex_d, ex_q;

  always_comb begin
    ex_d        = '0;
    ex_d.wreg   = dwreg;
    ex_d.m2reg  = dm2reg;
    ex_d.wmem   = dwmem;
    ex_d.jal    = djal;
    ex_d.aluc   = daluc;
    ex_d.aluimm = daluimm;
    ex_d.shift  = dshift;
    ex_d.a      = da;
    ex_d.b      = db;
    ex_d.imm    = dimm;
    ex_d.rn0    = drn;
    ex_d.pc4    = dpc4;
  end

  // No enable: stalls arrive as bubbles, so every edge overwrites the stage.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) ex_q <= '0;
    else       ex_q <= ex_d;
  end

  logic [WIDTH-1:0] a_op, b_op, alu_res, epc8;
  logic [4:0]       shamt;

  always_comb begin
    a_op  = ex_q.shift ? {{(WIDTH-5){1'b0}}, ex_q.imm[10:6]} : ex_q.a;
    b_op  = ex_q.aluimm ? ex_q.imm : ex_q.b;
    shamt = a_op[4:0];
    casez (ex_q.aluc)
      4'b?000: alu_res = a_op + b_op;
      4'b?100: alu_res = a_op - b_op;
      4'b?001: alu_res = a_op & b_op;
      4'b?101: alu_res = a_op | b_op;
      4'b?010: alu_res = a_op ^ b_op;
      4'b?110: alu_res = {b_op[15:0], 16'b0};
      4'b0011: alu_res = b_op << shamt;
      4'b0111: alu_res = b_op >> shamt;
      4'b1111: alu_res = $unsigned($signed(b_op) >>> shamt);
      default: alu_res = '0;
    endcase
    epc8 = ex_q.pc4 + WIDTH'(4);
  end

  assign ewreg  = ex_q.wreg;
  assign em2reg = ex_q.m2reg;
  assign ewmem  = ex_q.wmem;
  assign eb     = ex_q.b;
  assign ern    = ex_q.rn0 | {5{ex_q.jal}};
  assign ealu   = ex_q.jal ? epc8 : alu_res;

endmodule
